// File: rtl/ser2par_ce_gen_pkg.sv
// ----------------------------------------------------------------------------
// ser2par_ce_gen_pkg
// Shared definitions for the serial-to-parallel CE generator:
//   - FSM state encoding (IDLE=0, SHIFT=1)
//   - legal WIDTH range and a range-check helper
//   - constant clog2 helper used to size the bit counter
// ----------------------------------------------------------------------------
package ser2par_ce_gen_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 32;

   // Smallest r such that 2**r >= v (constant-evaluable).
   function automatic int unsigned clog2_fn(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'(1) << r) < 64'(v)) begin
         r = r + 1;
      end
      return r;
   endfunction

   // True when the word width is inside the supported range.
   function automatic bit width_ok(input int unsigned w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// ----------------------------------------------------------------------------
// ser_shift_reg
// Serial-in shift register that assembles one word.
// Ports:
//   C           clock, rising edge
//   CLR_N       asynchronous active-low clear
//   i_shift_en  shift i_sdi into the word this edge
//   i_clear     discard the held partial word (combined with i_shift_en the
//               incoming bit becomes the first bit of a fresh word)
//   i_sdi       serial data bit
//   o_word_c    word as it looks with i_sdi shifted in (combinational), so the
//               owner can commit a complete word on the edge that accepts the
//               last bit
// MSB_FIRST=1 shifts toward the MSB (first bit ends in [WIDTH-1]);
// MSB_FIRST=0 shifts toward the LSB (first bit ends in [0]).
// ----------------------------------------------------------------------------
module ser_shift_reg #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             C,
   input  logic             CLR_N,
   input  logic             i_shift_en,
   input  logic             i_clear,
   input  logic             i_sdi,
   output logic [WIDTH-1:0] o_word_c
);

   logic [WIDTH-1:0] r_word;
   logic [WIDTH-1:0] w_base;
   logic [WIDTH-1:0] w_next;

   // A clear starts the new word from zero before the incoming bit lands.
   assign w_base = i_clear ? '0 : r_word;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_next = {w_base[WIDTH-2:0], i_sdi};
      end else begin : g_lsb_first
         assign w_next = {i_sdi, w_base[WIDTH-1:1]};
      end
   endgenerate

   // Word storage.
   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         r_word <= '0;
      end else if (i_shift_en) begin
         r_word <= w_next;
      end else if (i_clear) begin
         r_word <= '0;
      end
   end

   assign o_word_c = w_next;

endmodule

// File: rtl/ser2par_ce_gen.sv
// ----------------------------------------------------------------------------
// ser2par_ce_gen
// Serial-to-parallel front end for a bank of falling-edge DFFs with sync reset
// and clock enable. Serial bits are assembled into WIDTH-bit words; each word
// is presented on D_OUT together with a one-cycle CE_OUT strobe. FLUSH issues
// a one-cycle R_OUT pulse. All outputs change on the rising edge of C so the
// downstream bank gets half a period of setup before its falling edge.
// Ports:
//   C       clock, rising edge
//   CLR_N   asynchronous active-low reset
//   SDI     serial data bit
//   SVALID  SDI valid this cycle
//   SYNC    with SVALID, marks the first bit of a word
//   FLUSH   synchronous clear request (highest priority)
//   D_OUT   last committed word (INIT after reset, 0 after FLUSH)
//   CE_OUT  one-cycle strobe when D_OUT takes a new word
//   R_OUT   one-cycle pulse on FLUSH
//   BUSY    a word is partially assembled
//   ERR     sticky: a partial word was abandoned by a new SYNC
// ----------------------------------------------------------------------------
module ser2par_ce_gen
   import ser2par_ce_gen_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter bit               MSB_FIRST = 1'b1,
   parameter logic [WIDTH-1:0] INIT      = '0
) (
   input  logic             C,
   input  logic             CLR_N,
   input  logic             SDI,
   input  logic             SVALID,
   input  logic             SYNC,
   input  logic             FLUSH,
   output logic [WIDTH-1:0] D_OUT,
   output logic             CE_OUT,
   output logic             R_OUT,
   output logic             BUSY,
   output logic             ERR
);

   localparam int unsigned      CNT_W    = clog2_fn(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("ser2par_ce_gen: WIDTH must be within 2..32");
      end
   endgenerate

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_dout;
   logic             r_ce;
   logic             r_r;
   logic             r_busy;
   logic             r_err;

   logic             w_sync_start;
   logic             w_shift_en;
   logic             w_clear;
   logic [WIDTH-1:0] w_next_word;

   // Shift-register control: a SYNC bit always restarts the word, plain bits
   // are only taken while a word is open, and FLUSH blocks any shift.
   assign w_sync_start = SVALID & SYNC;
   assign w_shift_en   = ~FLUSH & SVALID & (SYNC | (r_state == ST_SHIFT));
   assign w_clear      = FLUSH | w_sync_start;

   ser_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .C          (C),
      .CLR_N      (CLR_N),
      .i_shift_en (w_shift_en),
      .i_clear    (w_clear),
      .i_sdi      (SDI),
      .o_word_c   (w_next_word)
   );

   // Word-assembly FSM, bit counter and registered outputs.
   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_dout  <= INIT;
         r_ce    <= 1'b0;
         r_r     <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ce <= 1'b0;
         r_r  <= 1'b0;
         if (FLUSH) begin
            // Any word completing on this edge is dropped.
            r_r     <= 1'b1;
            r_dout  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_sync_start) begin
                     r_cnt   <= CNT_W'(1);
                     r_state <= ST_SHIFT;
                     r_busy  <= 1'b1;
                  end
               end
               ST_SHIFT: begin
                  if (SVALID) begin
                     if (SYNC) begin
                        // Partial word abandoned; this bit opens a new one.
                        r_err <= 1'b1;
                        r_cnt <= CNT_W'(1);
                     end else if (r_cnt == LAST_CNT) begin
                        r_dout  <= w_next_word;
                        r_ce    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign D_OUT  = r_dout;
   assign CE_OUT = r_ce;
   assign R_OUT  = r_r;
   assign BUSY   = r_busy;
   assign ERR    = r_err;

endmodule
